// File: rtl/reg_file_param.sv
// Parameterized register file with a single LOAD/ADD/CLEAR write port,
// two registered read ports with write-first bypass, and a sticky carry flag.
// All state, including reset, is updated on the rising edge of clk.
module reg_file_param #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0][WIDTH-1:0] w_regs_nxt;
  logic                        w_wr_eff;
  logic [WIDTH:0]              w_sum;
  logic [WIDTH-1:0]            w_wval;
  logic                        w_carry;

  // Reserved op (11) is treated exactly like no write at all.
  assign w_wr_eff = wr_en && (wr_op != 2'b11);

  // One extra bit catches the carry out of the ADD.
  assign w_sum   = {1'b0, r_regs[wr_addr]} + {1'b0, wr_data};
  assign w_carry = w_wr_eff && (wr_op == OP_ADD) && w_sum[WIDTH];

  // Value the targeted register takes for the current write op.
  always_comb begin
    w_wval = r_regs[wr_addr];
    case (wr_op)
      OP_LOAD:  w_wval = wr_data;
      OP_ADD:   w_wval = w_sum[WIDTH-1:0];
      OP_CLEAR: w_wval = '0;
      default:  w_wval = r_regs[wr_addr];
    endcase
  end

  // Post-write image of the file; feeds both the state and the read bypass.
  always_comb begin
    w_regs_nxt = r_regs;
    if (w_wr_eff) w_regs_nxt[wr_addr] = w_wval;
  end

  // Register array update; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) r_regs <= '0;
    else          r_regs <= w_regs_nxt;
  end

  // Registered read ports, reading the post-write image (write-first).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_en) begin
      rd_data_a <= w_regs_nxt[rd_addr_a];
      rd_data_b <= w_regs_nxt[rd_addr_b];
    end
  end

  // Sticky carry flag; a carrying ADD beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (w_carry) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (WIDTH=32, ADDR_W=3).
// A behavioural model of the register file is advanced on every edge and
// used to check the randomized phase; directed scenarios use fixed values.
module tb_reg_file_param;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [1:0]        wr_op;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              ovf;
  logic              clr_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [WIDTH-1:0] m_regs [DEPTH];
  logic [WIDTH-1:0] m_rda, m_rdb;
  logic             m_ovf;

  reg_file_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for an edge, advance the model from the inputs sampled there,
  // then step 1 time unit past the edge for sampling / next drive.
  task automatic tick();
    longint sum;
    logic [WIDTH-1:0] nv;
    bit carry;
    @(posedge clk);
    carry = 0;
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_rda = '0; m_rdb = '0; m_ovf = 1'b0;
    end else begin
      if (wr_en && wr_op != 2'd3) begin
        nv = m_regs[wr_addr];
        if (wr_op == 2'd0) nv = wr_data;
        else if (wr_op == 2'd2) nv = '0;
        else begin
          sum   = longint'(m_regs[wr_addr]) + longint'(wr_data);
          carry = (sum >= 64'h1_0000_0000);
          nv    = sum[WIDTH-1:0];
        end
        m_regs[wr_addr] = nv;
      end
      if (carry) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (rd_en) begin
        m_rda = m_regs[rd_addr_a];
        m_rdb = m_regs[rd_addr_b];
      end
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_op = 2'd0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_addr_a = '0; rd_addr_b = '0; clr_ovf = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    tick(); tick();
    n_cmp++; if (rd_data_a !== '0) begin n_fail++; $display("FAIL reset_rda: got %h want 0", rd_data_a); end
    n_cmp++; if (rd_data_b !== '0) begin n_fail++; $display("FAIL reset_rdb: got %h want 0", rd_data_b); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    reset_n = 1;
    rd_en = 1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = a[ADDR_W-1:0];
      rd_addr_b = 3'(DEPTH - 1 - a);
      tick();
      n_cmp++; if (rd_data_a !== '0 || rd_data_b !== '0) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %h/%h want 0/0", a, rd_data_a, rd_data_b);
      end
    end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_after: got %b want 0", ovf); end
    idle();
  endtask

  task automatic test_load_read();
    idle();
    wr_en = 1; wr_op = 2'd0; wr_addr = 3; wr_data = 32'h1234_5678;
    tick();
    n_cmp++; if (rd_data_a !== '0) begin n_fail++; $display("FAIL load_noread: got %h want 0", rd_data_a); end
    idle();
    rd_en = 1; rd_addr_a = 3; rd_addr_b = 3;
    tick();
    n_cmp++; if (rd_data_a !== 32'h1234_5678) begin n_fail++; $display("FAIL load_rda: got %h want 12345678", rd_data_a); end
    n_cmp++; if (rd_data_b !== 32'h1234_5678) begin n_fail++; $display("FAIL load_rdb: got %h want 12345678", rd_data_b); end
    idle();
  endtask

  task automatic test_add_ovf();
    idle();
    wr_en = 1; wr_op = 2'd0; wr_addr = 5; wr_data = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL add_preovf: got %b want 0", ovf); end
    wr_op = 2'd1; wr_data = 32'h0000_0002;
    tick();
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL add_ovf_set: got %b want 1", ovf); end
    idle();
    rd_en = 1; rd_addr_a = 5; rd_addr_b = 3;
    tick();
    n_cmp++; if (rd_data_a !== 32'h0000_0001) begin n_fail++; $display("FAIL add_wrap: got %h want 00000001", rd_data_a); end
    n_cmp++; if (rd_data_b !== 32'h1234_5678) begin n_fail++; $display("FAIL add_other_reg: got %h want 12345678", rd_data_b); end
    // LOAD and CLEAR must not touch the sticky flag
    idle();
    wr_en = 1; wr_op = 2'd0; wr_addr = 6; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_op = 2'd2; wr_addr = 4;
    tick();
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    idle(); clr_ovf = 1;
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    // carrying ADD beats a same-cycle clear (reg6 = FFFFFFFF)
    wr_en = 1; wr_op = 2'd1; wr_addr = 6; wr_data = 32'h1; clr_ovf = 1;
    tick();
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL add_beats_clr: got %b want 1", ovf); end
    // non-carrying ADD (reg6 now 0) lets the clear through
    wr_data = 32'h7FFF_FFFF;
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL nocarry_clr: got %b want 0", ovf); end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_op = 2'd0; wr_addr = 2; wr_data = 32'hA5A5_A5A5;
    rd_en = 1; rd_addr_a = 2; rd_addr_b = 2;
    tick();
    n_cmp++; if (rd_data_a !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_load_a: got %h want a5a5a5a5", rd_data_a); end
    n_cmp++; if (rd_data_b !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_load_b: got %h want a5a5a5a5", rd_data_b); end
    wr_op = 2'd1; wr_data = 32'h0101_0101; rd_addr_b = 6;
    tick();
    n_cmp++; if (rd_data_a !== 32'hA6A6_A6A6) begin n_fail++; $display("FAIL bypass_add: got %h want a6a6a6a6", rd_data_a); end
    n_cmp++; if (rd_data_b !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL bypass_other: got %h want 7fffffff", rd_data_b); end
    // reserved op leaves the register alone
    wr_op = 2'd3; wr_data = 32'h0BAD_0BAD;
    tick();
    n_cmp++; if (rd_data_a !== 32'hA6A6_A6A6) begin n_fail++; $display("FAIL reserved_op: got %h want a6a6a6a6", rd_data_a); end
    idle();
  endtask

  task automatic test_rd_hold();
    idle();
    wr_en = 1; wr_op = 2'd0; wr_addr = 4; wr_data = 32'h1111_1111;
    rd_en = 1; rd_addr_a = 4; rd_addr_b = 4;
    tick();
    wr_data = 32'hDEAD_BEEF; rd_en = 0;
    tick();
    n_cmp++; if (rd_data_a !== 32'h1111_1111) begin n_fail++; $display("FAIL hold_a: got %h want 11111111", rd_data_a); end
    idle();
    tick();
    n_cmp++; if (rd_data_b !== 32'h1111_1111) begin n_fail++; $display("FAIL hold_b: got %h want 11111111", rd_data_b); end
    rd_en = 1; rd_addr_a = 4;
    tick();
    n_cmp++; if (rd_data_a !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hold_release: got %h want deadbeef", rd_data_a); end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    // set ovf and a nonzero reg7
    wr_en = 1; wr_op = 2'd0; wr_addr = 7; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_op = 2'd1; wr_data = 32'h2;
    tick();
    wr_op = 2'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    idle();
    // low pulse between edges must be ignored
    #2 reset_n = 0;
    #2 reset_n = 1;
    rd_en = 1; rd_addr_a = 7; rd_addr_b = 2;
    tick();
    n_cmp++; if (rd_data_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL glitch_reg: got %h want ffffffff", rd_data_a); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL glitch_ovf: got %b want 1", ovf); end
    // reset with a carrying ADD pending
    reset_n = 0; wr_en = 1; wr_op = 2'd1; wr_addr = 7; wr_data = 32'h5;
    tick();
    n_cmp++; if (rd_data_a !== '0 || rd_data_b !== '0) begin n_fail++; $display("FAIL midrst_rd: got %h/%h want 0/0", rd_data_a, rd_data_b); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    reset_n = 1; idle(); rd_en = 1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = a[ADDR_W-1:0];
      rd_addr_b = 3'(DEPTH - 1 - a);
      tick();
      n_cmp++; if (rd_data_a !== '0 || rd_data_b !== '0) begin
        n_fail++; $display("FAIL midrst_reg[%0d]: got %h/%h want 0/0", a, rd_data_a, rd_data_b);
      end
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 600; i++) begin
      reset_n   = ($urandom_range(0, 59) != 0);
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_op     = 2'($urandom_range(0, 3));
      wr_addr   = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       wr_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       wr_data = 32'($urandom_range(0, 15));
        default: wr_data = $urandom;
      endcase
      rd_en     = ($urandom_range(0, 3) != 0);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      tick();
      n_cmp++; if (rd_data_a !== m_rda) begin n_fail++; $display("FAIL rand_rda[%0d]: got %h want %h", i, rd_data_a, m_rda); end
      n_cmp++; if (rd_data_b !== m_rdb) begin n_fail++; $display("FAIL rand_rdb[%0d]: got %h want %h", i, rd_data_b, m_rdb); end
      n_cmp++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, ovf, m_ovf); end
    end
    reset_n = 1;
    idle();
  endtask

  initial begin
    reset_n = 0;
    idle();
    test_reset();
    test_load_read();
    test_add_ovf();
    test_bypass();
    test_rd_hold();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, data width of each register (min 2).
REQ-002 The block SHALL expose parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port wr_en  input  1  write-port request.
REQ-006 The block SHALL have port wr_op  input  2  write operation: 00 LOAD, 01 ADD, 10 CLEAR, 11 reserved.
REQ-007 The block SHALL have port wr_addr  input  ADDR_W  target register.
REQ-008 The block SHALL have port wr_data  input  WIDTH  load value or addend.
REQ-009 The block SHALL have port rd_en  input  1  read-port update enable.
REQ-010 The block SHALL have port rd_addr_a  input  ADDR_W  read port A address.
REQ-011 The block SHALL have port rd_addr_b  input  ADDR_W  read port B address.
REQ-012 The block SHALL have port rd_data_a  output  WIDTH  registered read data A.
REQ-013 The block SHALL have port rd_data_b  output  WIDTH  registered read data B.
REQ-014 The block SHALL have port ovf  output  1  sticky ADD-carry flag.
REQ-015 The block SHALL have port clr_ovf  input  1  clears ovf.

Function
REQ-016 Write: on a clk edge with reset_n=1 and wr_en=1, reg[wr_addr] SHALL become wr_data (LOAD), reg[wr_addr]+wr_data mod 2**WIDTH (ADD), or 0 (CLEAR).
REQ-017 wr_op=11 or wr_en=0 SHALL leave all registers unchanged; only reg[wr_addr] may change per cycle.
REQ-018 Read: on a clk edge with rd_en=1, rd_data_a/rd_data_b SHALL load the value of reg[rd_addr_a]/reg[rd_addr_b]; latency exactly 1 cycle.
REQ-019 rd_en=0 SHALL hold rd_data_a and rd_data_b at their previous values.
REQ-020 Bypass: when rd_en=1 and a read address equals wr_addr of a same-cycle effective write, that port SHALL load the post-write value (write-first).
REQ-021 Both read ports SHALL be independent; rd_addr_a = rd_addr_b SHALL give identical data.
REQ-022 ovf SHALL set on an effective ADD whose true sum >= 2**WIDTH, remain set until cleared, and not be affected by LOAD/CLEAR.
REQ-023 clr_ovf=1 SHALL clear ovf on the next edge; a same-cycle carrying ADD SHALL win (ovf=1).
REQ-024 Registers SHALL have no other modifier; no combinational path from any input to any output.

Reset
REQ-025 On a clk edge with reset_n=0, all DEPTH registers, rd_data_a, rd_data_b and ovf SHALL become 0, overriding every other input.
REQ-026 Reset SHALL act only at clk edges; a reset_n low pulse between edges SHALL have no effect.
REQ-027 A write or read requested in the reset cycle SHALL be discarded; first effective operation is on the first edge with reset_n=1.

Verification (WIDTH=32, ADDR_W=3)
REQ-028 Reset, then rd_en=1, rd_addr_a=0..7 -> rd_data_a=0 for every address, ovf=0.
REQ-029 LOAD 0x12345678 to reg 3, next cycle read A=3, B=3 -> both outputs 0x12345678 one edge after read request.
REQ-030 LOAD 0xFFFFFFFF to reg 5, then ADD 0x00000002 to reg 5 -> reg 5 = 0x00000001, ovf=1; then clr_ovf=1 -> ovf=0.
REQ-031 Same cycle: LOAD 0xA5A5A5A5 to reg 2 with rd_addr_a=2, rd_en=1 -> rd_data_a=0xA5A5A5A5 after that edge (bypass); ADD with bypass returns the sum.
REQ-032 rd_en=0 while writing 0xDEADBEEF to the currently read address -> rd_data_a unchanged until rd_en returns to 1.
REQ-033 reset_n=0 asserted mid-stream with wr_en=1, wr_op=ADD, carry condition -> all registers, read outputs and ovf = 0 after the edge; no write applied.
